// File: rtl/aes_pkg.sv
// Shared AES types, constant tables and byte/word helper functions used by
// the AES-256 encrypt and decrypt tops.
package aes_pkg;

   typedef logic [127:0] block_t;
   typedef logic [31:0]  word_t;
   typedef block_t       rk_array_t [0:14];

   typedef enum logic [2:0] {
      ST_NOKEY  = 3'd0,
      ST_EXPAND = 3'd1,
      ST_IDLE   = 3'd2,
      ST_RUN    = 3'd3,
      ST_OUT    = 3'd4
   } dec_state_e;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Inverse S-box, entry 0 in the most significant byte.
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   // Round constants; index 0 is never used by the AES-256 schedule.
   localparam logic [0:7][7:0] RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
   };

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant built from the powers 1, 2, 4, 8.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
      logic [7:0] x2, x4, x8;
      x2 = gf_mul2(a);
      x4 = gf_mul2(x2);
      x8 = gf_mul2(x4);
      return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
             (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // Byte i of a block is [127-8i -: 8], with i = row + 4*column.
   function automatic block_t inv_shift_rows(input block_t s);
      block_t o;
      o = s;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic block_t inv_sub_bytes(input block_t s);
      block_t o;
      o = s;
      for (int i = 0; i < 16; i++) begin
         o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
      end
      return o;
   endfunction

   function automatic block_t inv_mix_columns(input block_t s);
      block_t     o;
      logic [7:0] a0, a1, a2, a3;
      o = s;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
         o[119-32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
         o[111-32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
         o[103-32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey and, except on the last round, InvMixColumns.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_rk,
   input  logic         i_last,
   output logic [127:0] o_state
);

   block_t w_added;

   // Inverse round datapath; the final round skips InvMixColumns.
   always_comb begin
      w_added = inv_sub_bytes(inv_shift_rows(i_state)) ^ i_rk;
      if (i_last) begin
         o_state = w_added;
      end else begin
         o_state = inv_mix_columns(w_added);
      end
   end

endmodule

// File: rtl/aes256_decrypt_core.sv
// Iterative AES-256 inverse cipher: expands the key once into 15 stored
// round keys, then decrypts one block per 15 cycles, one round per clock.
module aes256_decrypt_core
   import aes_pkg::*;
#(
   parameter int NR = 14,
   parameter int NK = 8
)(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [255:0] key_i,
   input  logic         key_valid_i,
   output logic         key_ready_o,
   input  logic [127:0] ct_i,
   input  logic         ct_valid_i,
   output logic         ct_ready_o,
   output logic [127:0] pt_o,
   output logic         pt_valid_o,
   input  logic         pt_ready_i,
   output logic         key_loaded_o
);

   generate
      if (NR != 14 || NK != 8) begin : g_bad_param
         $fatal(1, "aes256_decrypt_core supports only NR=14, NK=8");
      end
   endgenerate

   localparam logic [3:0] LAST_KIDX = 4'(NR);
   localparam logic [3:0] FIRST_RND = 4'(NR - 1);

   dec_state_e r_state, w_state_nxt;
   rk_array_t  r_rk;
   logic [3:0] r_kidx;
   logic [3:0] r_rnd;
   block_t     r_blk;
   block_t     r_pt;
   logic       r_pt_valid;
   logic       r_key_loaded;

   logic       w_key_ready, w_ct_ready;
   logic       w_key_fire, w_ct_fire;
   block_t     w_prev2, w_prev1, w_rk_new, w_round_out;
   word_t      w_temp, w_n0, w_n1, w_n2, w_n3;
   block_t     w_rk_sel;
   logic       w_last;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_NOKEY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and ready decode; a key request beats a simultaneous block.
   always_comb begin
      w_state_nxt = r_state;
      w_key_ready = 1'b0;
      w_ct_ready  = 1'b0;
      case (r_state)
         ST_NOKEY: begin
            w_key_ready = 1'b1;
            if (key_valid_i) w_state_nxt = ST_EXPAND;
            else             w_state_nxt = ST_NOKEY;
         end
         ST_EXPAND: begin
            if (r_kidx == LAST_KIDX) w_state_nxt = ST_IDLE;
            else                     w_state_nxt = ST_EXPAND;
         end
         ST_IDLE: begin
            w_key_ready = 1'b1;
            w_ct_ready  = !key_valid_i;
            if (key_valid_i)     w_state_nxt = ST_EXPAND;
            else if (ct_valid_i) w_state_nxt = ST_RUN;
            else                 w_state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (r_rnd == 4'd0) w_state_nxt = ST_OUT;
            else               w_state_nxt = ST_RUN;
         end
         ST_OUT: begin
            // Taking the next block in the same cycle the result leaves
            // keeps the 15-cycle cadence when the consumer never stalls.
            w_ct_ready = pt_ready_i && !key_valid_i;
            if (pt_ready_i && ct_valid_i && !key_valid_i) w_state_nxt = ST_RUN;
            else if (pt_ready_i)                          w_state_nxt = ST_IDLE;
            else                                          w_state_nxt = ST_OUT;
         end
         default: begin
            w_state_nxt = ST_NOKEY;
         end
      endcase
   end

   assign key_ready_o = w_key_ready;
   assign ct_ready_o  = w_ct_ready;
   assign w_key_fire  = key_valid_i && w_key_ready;
   assign w_ct_fire   = ct_valid_i && w_ct_ready;

   // Key schedule step: rk[kidx] from rk[kidx-2] and the last word of rk[kidx-1].
   always_comb begin
      w_prev2 = r_rk[r_kidx - 4'd2];
      w_prev1 = r_rk[r_kidx - 4'd1];
      if (!r_kidx[0]) begin
         w_temp = sub_word(rot_word(w_prev1[31:0])) ^ {RCON[r_kidx[3:1]], 24'h000000};
      end else begin
         w_temp = sub_word(w_prev1[31:0]);
      end
      w_n0     = w_prev2[127:96] ^ w_temp;
      w_n1     = w_prev2[95:64]  ^ w_n0;
      w_n2     = w_prev2[63:32]  ^ w_n1;
      w_n3     = w_prev2[31:0]   ^ w_n2;
      w_rk_new = {w_n0, w_n1, w_n2, w_n3};
   end

   assign w_rk_sel = r_rk[r_rnd];
   assign w_last   = (r_rnd == 4'd0);

   aes_inv_round u_inv_round (
      .i_state (r_blk),
      .i_rk    (w_rk_sel),
      .i_last  (w_last),
      .o_state (w_round_out)
   );

   // Key store, round state and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 15; i++) begin
            r_rk[i] <= 128'h0;
         end
         r_kidx       <= 4'd0;
         r_rnd        <= 4'd0;
         r_blk        <= 128'h0;
         r_pt         <= 128'h0;
         r_pt_valid   <= 1'b0;
         r_key_loaded <= 1'b0;
      end else begin
         case (r_state)
            ST_NOKEY, ST_IDLE: begin
               if (w_key_fire) begin
                  r_rk[0]      <= key_i[255:128];
                  r_rk[1]      <= key_i[127:0];
                  r_kidx       <= 4'd2;
                  r_key_loaded <= 1'b0;
               end else if (w_ct_fire) begin
                  r_blk <= ct_i ^ r_rk[14];
                  r_rnd <= FIRST_RND;
               end
            end
            ST_EXPAND: begin
               r_rk[r_kidx] <= w_rk_new;
               r_kidx       <= r_kidx + 4'd1;
               if (r_kidx == LAST_KIDX) r_key_loaded <= 1'b1;
            end
            ST_RUN: begin
               r_blk <= w_round_out;
               if (r_rnd == 4'd0) begin
                  r_pt       <= w_round_out;
                  r_pt_valid <= 1'b1;
               end else begin
                  r_rnd <= r_rnd - 4'd1;
               end
            end
            ST_OUT: begin
               if (pt_ready_i) begin
                  r_pt_valid <= 1'b0;
                  if (w_ct_fire) begin
                     r_blk <= ct_i ^ r_rk[14];
                     r_rnd <= FIRST_RND;
                  end
               end
            end
            default: begin
               r_pt_valid <= 1'b0;
            end
         endcase
      end
   end

   assign pt_o         = r_pt;
   assign pt_valid_o   = r_pt_valid;
   assign key_loaded_o = r_key_loaded;

endmodule

// File: tb/tb_aes256_decrypt_core.sv
// Directed bench for aes256_decrypt_core using published AES-256 vectors.
module tb_aes256_decrypt_core;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b1;
   logic [255:0] key_i = 256'h0;
   logic         key_valid_i = 1'b0;
   logic         key_ready_o;
   logic [127:0] ct_i = 128'h0;
   logic         ct_valid_i = 1'b0;
   logic         ct_ready_o;
   logic [127:0] pt_o;
   logic         pt_valid_o;
   logic         pt_ready_i = 1'b0;
   logic         key_loaded_o;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY_F16 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] B2B_CT [3] = '{128'hf3eed1bdb5d2a03c064b5a7e3db181f8,
                                           128'h591ccb10d410ed26dc5ba74a31362870,
                                           128'hb6ed21b99ca6f4f9f153e7b1beafed1d};
   localparam logic [127:0] B2B_PT [3] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                                           128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                           128'h30c81c46a35ce411e5fbc1191a0a52ef};

   always #5 clk_i = ~clk_i;

   aes256_decrypt_core dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .key_i        (key_i),
      .key_valid_i  (key_valid_i),
      .key_ready_o  (key_ready_o),
      .ct_i         (ct_i),
      .ct_valid_i   (ct_valid_i),
      .ct_ready_o   (ct_ready_o),
      .pt_o         (pt_o),
      .pt_valid_o   (pt_valid_o),
      .pt_ready_i   (pt_ready_i),
      .key_loaded_o (key_loaded_o)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_key(input logic [255:0] k);
      int g;
      g = 0;
      @(negedge clk_i);
      key_i       = k;
      key_valid_i = 1'b1;
      while (!key_ready_o && g < 100) begin
         @(negedge clk_i);
         g++;
      end
      check("key_ready_at_load", 128'(key_ready_o), 128'd1);
      @(posedge clk_i);
      #1;
      key_valid_i = 1'b0;
   endtask

   task automatic send_ct(input logic [127:0] ct);
      int g;
      g = 0;
      @(negedge clk_i);
      ct_i       = ct;
      ct_valid_i = 1'b1;
      while (!ct_ready_o && g < 100) begin
         @(negedge clk_i);
         g++;
      end
      check("ct_ready_at_send", 128'(ct_ready_o), 128'd1);
      @(posedge clk_i);
      #1;
      ct_valid_i = 1'b0;
   endtask

   // Edges counted from the call (made #1 after a handshake edge) until the flag is seen.
   task automatic wait_key_loaded(output int n);
      n = 0;
      while (!key_loaded_o && n < 40) begin
         @(posedge clk_i);
         #1;
         n++;
      end
   endtask

   task automatic wait_pt_valid(output int n);
      n = 0;
      while (!pt_valid_o && n < 40) begin
         @(posedge clk_i);
         #1;
         n++;
      end
   endtask

   initial begin
      int n;
      int nsent, nrecv, cyc, last_got;
      logic acc, got;

      // Reset state
      #1 rst_ni = 1'b0;
      #2;
      check("rst_pt_valid", 128'(pt_valid_o), 128'd0);
      check("rst_key_loaded", 128'(key_loaded_o), 128'd0);
      check("rst_pt", pt_o, 128'h0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("nokey_key_ready", 128'(key_ready_o), 128'd1);
      check("nokey_ct_ready", 128'(ct_ready_o), 128'd0);

      // FIPS-197 C.3: expansion takes 13 cycles, decryption 14 edges
      load_key(KEY_C3);
      check("expand_key_ready", 128'(key_ready_o), 128'd0);
      check("expand_ct_ready", 128'(ct_ready_o), 128'd0);
      wait_key_loaded(n);
      check("c3_expand_latency", 128'(n), 128'd13);
      check("idle_ct_ready", 128'(ct_ready_o), 128'd1);
      send_ct(CT_C3);
      wait_pt_valid(n);
      check("c3_latency", 128'(n), 128'd14);
      check("c3_pt", pt_o, PT_C3);

      // Backpressure: result held for 20 cycles, then a single-cycle ready
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         check("bp_pt_stable", pt_o, PT_C3);
         check("bp_pt_valid", 128'(pt_valid_o), 128'd1);
         check("bp_ct_ready", 128'(ct_ready_o), 128'd0);
      end
      @(negedge clk_i);
      pt_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      pt_ready_i = 1'b0;
      check("bp_release_pt_valid", 128'(pt_valid_o), 128'd0);
      check("bp_release_ct_ready", 128'(ct_ready_o), 128'd1);

      // Simultaneous key + block in IDLE: key wins, block waits for new schedule
      @(negedge clk_i);
      key_i       = KEY_F16;
      key_valid_i = 1'b1;
      ct_i        = B2B_CT[0];
      ct_valid_i  = 1'b1;
      #1;
      check("simul_ct_ready", 128'(ct_ready_o), 128'd0);
      check("simul_key_ready", 128'(key_ready_o), 128'd1);
      @(posedge clk_i);
      #1;
      key_valid_i = 1'b0;
      check("simul_key_loaded_clr", 128'(key_loaded_o), 128'd0);
      check("simul_expand_ct_ready", 128'(ct_ready_o), 128'd0);
      wait_key_loaded(n);
      check("f16_expand_latency", 128'(n), 128'd13);
      @(posedge clk_i);
      #1;
      ct_valid_i = 1'b0;
      wait_pt_valid(n);
      check("simul_latency", 128'(n), 128'd14);
      check("f16_pt", pt_o, B2B_PT[0]);
      @(negedge clk_i);
      pt_ready_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Back-to-back: three F.1.6 ECB blocks, one result every 15 cycles
      nsent    = 0;
      nrecv    = 0;
      cyc      = 0;
      last_got = 0;
      @(negedge clk_i);
      ct_i       = B2B_CT[0];
      ct_valid_i = 1'b1;
      while (nrecv < 3 && cyc < 200) begin
         acc = ct_valid_i && ct_ready_o;
         got = pt_valid_o && pt_ready_i;
         if (got) begin
            check("b2b_pt", pt_o, B2B_PT[nrecv]);
            if (nrecv > 0) check("b2b_spacing", 128'(cyc - last_got), 128'd15);
            last_got = cyc;
            nrecv++;
         end
         @(posedge clk_i);
         cyc++;
         #1;
         if (acc) begin
            nsent++;
            if (nsent < 3) ct_i = B2B_CT[nsent];
            else           ct_valid_i = 1'b0;
         end
         @(negedge clk_i);
      end
      ct_valid_i = 1'b0;
      check("b2b_count", 128'(nrecv), 128'd3);

      // Reset in the middle of a decryption (round 7)
      load_key(KEY_C3);
      wait_key_loaded(n);
      check("reload_c3_latency", 128'(n), 128'd13);
      send_ct(CT_C3);
      repeat (6) @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      check("midrun_rst_pt_valid", 128'(pt_valid_o), 128'd0);
      check("midrun_rst_key_loaded", 128'(key_loaded_o), 128'd0);
      check("midrun_rst_ct_ready", 128'(ct_ready_o), 128'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni     = 1'b1;
      ct_i       = CT_C3;
      ct_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("post_rst_ct_ready", 128'(ct_ready_o), 128'd0);
         check("post_rst_pt_valid", 128'(pt_valid_o), 128'd0);
      end
      ct_valid_i = 1'b0;
      load_key(KEY_C3);
      wait_key_loaded(n);
      check("post_rst_expand_latency", 128'(n), 128'd13);
      send_ct(CT_C3);
      wait_pt_valid(n);
      check("post_rst_latency", 128'(n), 128'd14);
      check("post_rst_pt", pt_o, PT_C3);
      @(negedge clk_i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
